// File: rtl/cam_partitioned_dyn.sv
// Multi-ported CAM with independently power-gated partitions. Each partition
// re-initialises its entries one per cycle whenever it leaves the gated state.
module cam_partitioned_dyn #(
    parameter int    DEPTH         = 64,
    parameter int    INDEX         = 6,
    parameter int    WIDTH         = 7,
    parameter int    NUM_WR_PORTS  = 4,
    parameter int    NUM_RD_PORTS  = 4,
    parameter int    NUM_PARTS     = 4,
    parameter int    NUM_PARTS_LOG = 2,
    parameter string RESET_VAL     = "ZERO",
    parameter int    SEQ_START     = 0,
    parameter bit    READ_REG      = 1'b0
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_WR_PORTS-1:0]                  writePortGated_i,
    input  logic [NUM_RD_PORTS-1:0]                  readPortGated_i,
    input  logic [NUM_PARTS-1:0]                     partitionGated_i,
    input  logic [NUM_RD_PORTS-1:0][WIDTH-1:0]       tag_i,
    output logic [NUM_RD_PORTS-1:0][DEPTH-1:0]       vect_o,
    input  logic [NUM_WR_PORTS-1:0][INDEX-1:0]       addrWr_i,
    input  logic [NUM_WR_PORTS-1:0][WIDTH-1:0]       dataWr_i,
    input  logic [NUM_WR_PORTS-1:0]                  wrEn_i,
    output logic [NUM_PARTS-1:0][1:0]                partState_o,
    output logic                                     ramReady_o
);

    localparam int PD       = DEPTH / NUM_PARTS;
    localparam int CNT_W    = INDEX - NUM_PARTS_LOG;
    localparam bit SEQ_INIT = (RESET_VAL == "SEQ");

    typedef enum logic [1:0] {
        GATED  = 2'd0,
        INIT   = 2'd1,
        ACTIVE = 2'd2
    } partState_t;

    partState_t       stateQ [NUM_PARTS];
    partState_t       stateD [NUM_PARTS];
    logic [CNT_W-1:0] cntQ   [NUM_PARTS];
    logic [CNT_W-1:0] cntD   [NUM_PARTS];
    logic [NUM_PARTS-1:0] initWr;

    logic [WIDTH-1:0] mem     [DEPTH];
    logic [DEPTH-1:0] entWe;
    logic [WIDTH-1:0] entData [DEPTH];

    logic [NUM_RD_PORTS-1:0][DEPTH-1:0] matchD;

    // NOTE: every variable written in an always_comb gets a default first, so
    // no path through the case statement can leave a latch behind.
    always_comb begin
        for (int p = 0; p < NUM_PARTS; p++) begin
            stateD[p] = stateQ[p];
            cntD[p]   = cntQ[p];
            initWr[p] = 1'b0;
            case (stateQ[p])
                GATED: begin
                    if (!partitionGated_i[p]) begin
                        stateD[p] = INIT;
                        cntD[p]   = '0;
                    end
                end
                INIT: begin
                    if (partitionGated_i[p]) begin
                        stateD[p] = GATED;
                        cntD[p]   = '0;
                    end else begin
                        initWr[p] = 1'b1;
                        if (cntQ[p] == CNT_W'(PD - 1)) begin
                            stateD[p] = ACTIVE;
                            cntD[p]   = '0;
                        end else begin
                            cntD[p] = cntQ[p] + 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (partitionGated_i[p]) stateD[p] = GATED;
                end
                default: begin
                    stateD[p] = INIT;
                    cntD[p]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PARTS; p++) begin
                stateQ[p] <= INIT;
                cntQ[p]   <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PARTS; p++) begin
                stateQ[p] <= stateD[p];
                cntQ[p]   <= cntD[p];
            end
        end
    end

    // Per-entry write decode. INIT and port writes never target the same
    // partition in one cycle; later ports override earlier ones on a clash.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            entWe[e]   = 1'b0;
            entData[e] = '0;
        end
        for (int p = 0; p < NUM_PARTS; p++) begin
            if (initWr[p]) begin
                entWe[p*PD + int'(cntQ[p])]   = 1'b1;
                entData[p*PD + int'(cntQ[p])] = SEQ_INIT ?
                    WIDTH'(SEQ_START + p*PD + int'(cntQ[p])) : '0;
            end
        end
        for (int w = 0; w < NUM_WR_PORTS; w++) begin
            if (wrEn_i[w] && !writePortGated_i[w] &&
                stateQ[int'(addrWr_i[w]) / PD] == ACTIVE &&
                !partitionGated_i[int'(addrWr_i[w]) / PD]) begin
                entWe[addrWr_i[w]]   = 1'b1;
                entData[addrWr_i[w]] = dataWr_i[w];
            end
        end
    end

    // NOTE: the storage array has no reset; its contents are only defined
    // once a partition has completed INIT, and the FSM blocks all reads until then.
    always_ff @(posedge clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (entWe[e]) mem[e] <= entData[e];
        end
    end

    always_comb begin
        for (int rp = 0; rp < NUM_RD_PORTS; rp++) begin
            for (int e = 0; e < DEPTH; e++) begin
                matchD[rp][e] = !readPortGated_i[rp] &&
                                (stateQ[e / PD] == ACTIVE) &&
                                (mem[e] == tag_i[rp]);
            end
        end
    end

    generate
        if (READ_REG) begin : gRegMatch
            logic [NUM_RD_PORTS-1:0][DEPTH-1:0] vectQ;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) vectQ <= '0;
                else        vectQ <= matchD;
            end
            assign vect_o = vectQ;
        end else begin : gCombMatch
            assign vect_o = matchD;
        end
    endgenerate

    always_comb begin
        ramReady_o = 1'b1;
        for (int p = 0; p < NUM_PARTS; p++) begin
            partState_o[p] = stateQ[p];
            if (stateQ[p] == INIT) ramReady_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_cam_partitioned_dyn.sv
// Scoreboard bench: stimulus queues expectations tagged with a due cycle, a
// negedge monitor compares them against a combinational and a registered CAM.
module tb_cam_partitioned_dyn;

    localparam int DEPTH = 16;
    localparam int INDEX = 4;
    localparam int WIDTH = 8;
    localparam int NWR   = 2;
    localparam int NRD   = 2;
    localparam int NP    = 4;
    localparam int NPL   = 2;

    logic clk = 1'b0;
    logic reset;
    logic [NWR-1:0]                writePortGated;
    logic [NWR-1:0]                wrEn;
    logic [NRD-1:0]                readPortGated;
    logic [NP-1:0]                 partitionGated;
    logic [NRD-1:0][WIDTH-1:0]     tag;
    logic [NWR-1:0][INDEX-1:0]     addrWr;
    logic [NWR-1:0][WIDTH-1:0]     dataWr;
    logic [NRD-1:0][DEPTH-1:0]     vectA, vectB;
    logic [NP-1:0][1:0]            partStateA, partStateB;
    logic                          readyA, readyB;

    cam_partitioned_dyn #(
        .DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH), .NUM_WR_PORTS(NWR),
        .NUM_RD_PORTS(NRD), .NUM_PARTS(NP), .NUM_PARTS_LOG(NPL),
        .RESET_VAL("SEQ"), .SEQ_START(8'h10), .READ_REG(1'b0)
    ) dutComb (
        .clk(clk), .reset(reset),
        .writePortGated_i(writePortGated), .readPortGated_i(readPortGated),
        .partitionGated_i(partitionGated), .tag_i(tag), .vect_o(vectA),
        .addrWr_i(addrWr), .dataWr_i(dataWr), .wrEn_i(wrEn),
        .partState_o(partStateA), .ramReady_o(readyA)
    );

    cam_partitioned_dyn #(
        .DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH), .NUM_WR_PORTS(NWR),
        .NUM_RD_PORTS(NRD), .NUM_PARTS(NP), .NUM_PARTS_LOG(NPL),
        .RESET_VAL("SEQ"), .SEQ_START(8'h10), .READ_REG(1'b1)
    ) dutReg (
        .clk(clk), .reset(reset),
        .writePortGated_i(writePortGated), .readPortGated_i(readPortGated),
        .partitionGated_i(partitionGated), .tag_i(tag), .vect_o(vectB),
        .addrWr_i(addrWr), .dataWr_i(dataWr), .wrEn_i(wrEn),
        .partState_o(partStateB), .ramReady_o(readyB)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] exp;
        int          due;
    } exp_t;

    exp_t sbQ[$];
    int   tests  = 0;
    int   failed = 0;

    localparam int S_VEC0 = 0, S_VEC1 = 1, S_RDY = 2, S_STATE = 3;
    localparam int S_RVEC0 = 4, S_RRDY = 5, S_RSTATE = 6, S_RVEC1 = 7;

    function automatic logic [15:0] observe(int sel);
        case (sel)
            S_VEC0:   return vectA[0];
            S_VEC1:   return vectA[1];
            S_RDY:    return {15'b0, readyA};
            S_STATE:  return {8'b0, partStateA};
            S_RVEC0:  return vectB[0];
            S_RRDY:   return {15'b0, readyB};
            S_RSTATE: return {8'b0, partStateB};
            default:  return vectB[1];
        endcase
    endfunction

    task automatic check(string name, logic [15:0] got, logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic expectAt(string name, int sel, logic [15:0] exp, int dly = 0);
        exp_t item;
        item.name = name;
        item.sel  = sel;
        item.exp  = exp;
        item.due  = cyc + dly;
        sbQ.push_back(item);
    endtask

    task automatic step(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: retire every expectation that falls due in the current cycle.
    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sbQ.size()) begin
            if (sbQ[i].due == cyc) begin
                check(sbQ[i].name, observe(sbQ[i].sel), sbQ[i].exp);
                sbQ.delete(i);
            end else begin
                i++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        writePortGated = '0; readPortGated = '0; partitionGated = '0;
        wrEn = '0; addrWr = '0; dataWr = '0; tag = '0;
        step(2);

        // Reset state
        tag[0] = 8'h10; tag[1] = 8'h11;
        expectAt("rst_vect0", S_VEC0, 16'h0000);
        expectAt("rst_vectReg", S_RVEC0, 16'h0000);
        expectAt("rst_ready", S_RDY, 16'h0000);
        expectAt("rst_state", S_STATE, 16'h0055);
        expectAt("rst_stateReg", S_RSTATE, 16'h0055);
        step();

        // Release: four INIT cycles, then SEQ contents visible
        reset = 1'b1;
        for (int k = 0; k < 4; k++) expectAt("init_ready", S_RDY, 16'h0000, k);
        expectAt("init_done", S_RDY, 16'h0001, 4);
        expectAt("init_doneReg", S_RRDY, 16'h0001, 4);
        step(4);
        tag[0] = 8'h15; tag[1] = 8'h1F;
        expectAt("seq_hit5", S_VEC0, 16'h0020);
        expectAt("seq_hit15", S_VEC1, 16'h8000);
        expectAt("all_active", S_STATE, 16'h00AA);
        expectAt("reg_lag", S_RVEC0, 16'h0000);
        expectAt("reg_hit5", S_RVEC0, 16'h0020, 1);
        step();

        // Registered match latency and read-port gating
        tag[0] = 8'h13;
        expectAt("seq_hit3", S_VEC0, 16'h0008);
        expectAt("reg_hit3", S_RVEC0, 16'h0008, 1);
        step();
        readPortGated = 2'b01; tag[1] = 8'h13;
        expectAt("rdgate_comb", S_VEC0, 16'h0000);
        expectAt("rdgate_other", S_VEC1, 16'h0008);
        expectAt("rdgate_reg", S_RVEC0, 16'h0000, 1);
        expectAt("rdgate_regOther", S_RVEC1, 16'h0008, 1);
        step();
        readPortGated = 2'b00;
        expectAt("reg_regain", S_RVEC0, 16'h0008, 1);
        step(2);

        // Same-address write conflict: highest port wins, read sees old data
        addrWr[0] = 4'd9; dataWr[0] = 8'hAA;
        addrWr[1] = 4'd9; dataWr[1] = 8'hBB;
        wrEn = 2'b11; tag[0] = 8'h19; tag[1] = 8'hBB;
        expectAt("wr_readOld", S_VEC0, 16'h0200);
        expectAt("wr_notYet", S_VEC1, 16'h0000);
        step();
        wrEn = 2'b00; tag[0] = 8'hBB; tag[1] = 8'hAA;
        expectAt("conflict_win", S_VEC0, 16'h0200);
        expectAt("conflict_lose", S_VEC1, 16'h0000);

        // Distinct addresses both commit
        addrWr[0] = 4'd3;  dataWr[0] = 8'h33;
        addrWr[1] = 4'd12; dataWr[1] = 8'h44;
        wrEn = 2'b11;
        step();
        wrEn = 2'b00; tag[0] = 8'h33; tag[1] = 8'h44;
        expectAt("dual_wr0", S_VEC0, 16'h0008);
        expectAt("dual_wr1", S_VEC1, 16'h1000);

        // Gated write port drops its write, the other port commits
        writePortGated = 2'b10;
        addrWr[0] = 4'd1; dataWr[0] = 8'h66;
        addrWr[1] = 4'd0; dataWr[1] = 8'h77;
        wrEn = 2'b11;
        step();
        writePortGated = 2'b00; wrEn = 2'b00;
        tag[0] = 8'h77; tag[1] = 8'h66;
        expectAt("wpgate_drop", S_VEC0, 16'h0000);
        expectAt("wpgate_keep", S_VEC1, 16'h0002);
        step();

        // Gate partition 2
        partitionGated = 4'b0100; tag[0] = 8'h1A; tag[1] = 8'h18;
        expectAt("gate_stillActive", S_VEC0, 16'h0400);
        step();
        expectAt("gated_miss", S_VEC0, 16'h0000);
        expectAt("gated_miss2", S_VEC1, 16'h0000);
        expectAt("gated_state", S_STATE, 16'h008A);
        expectAt("gated_ready", S_RDY, 16'h0001);
        addrWr[0] = 4'd10; dataWr[0] = 8'h55; wrEn = 2'b01;
        step();
        wrEn = 2'b00; partitionGated = 4'b0000;
        expectAt("ungate_ready", S_RDY, 16'h0001);
        expectAt("reinit_state", S_STATE, 16'h009A, 1);
        for (int k = 1; k <= 4; k++) expectAt("reinit_ready", S_RDY, 16'h0000, k);
        expectAt("reinit_done", S_RDY, 16'h0001, 5);
        step(5);
        tag[0] = 8'h1A; tag[1] = 8'h55;
        expectAt("reinit_seq", S_VEC0, 16'h0400);
        expectAt("gated_wr_dropped", S_VEC1, 16'h0000);
        step();

        // Asynchronous reset mid-operation
        reset = 1'b0; tag[0] = 8'h10; tag[1] = 8'h19;
        expectAt("arst_vect0", S_VEC0, 16'h0000);
        expectAt("arst_vect1", S_VEC1, 16'h0000);
        expectAt("arst_vectReg", S_RVEC0, 16'h0000);
        expectAt("arst_ready", S_RDY, 16'h0000);
        expectAt("arst_state", S_STATE, 16'h0055);
        step();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        expectAt("midinit_state", S_STATE, 16'h0055);
        expectAt("midinit_ready", S_RDY, 16'h0000);
        step();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) expectAt("rerst_ready", S_RDY, 16'h0000, k);
        expectAt("rerst_done", S_RDY, 16'h0001, 4);
        step(4);
        expectAt("rerst_seq0", S_VEC0, 16'h0001);
        expectAt("rerst_seq9", S_VEC1, 16'h0200);
        step();
        tag[0] = 8'hBB; tag[1] = 8'h1C;
        expectAt("rerst_oldGone", S_VEC0, 16'h0000);
        expectAt("rerst_seq12", S_VEC1, 16'h1000);
        step();

        // Gate partition 1 during its second INIT cycle
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        partitionGated = 4'b0010;
        step();
        expectAt("initgate_state", S_STATE, 16'h0051);
        expectAt("initgate_ready", S_RDY, 16'h0000);
        step();
        expectAt("initgate_ready2", S_RDY, 16'h0000);
        step();
        tag[0] = 8'h15; tag[1] = 8'h11;
        expectAt("initgate_others", S_RDY, 16'h0001);
        expectAt("initgate_stateA", S_STATE, 16'h00A2);
        expectAt("initgate_miss", S_VEC0, 16'h0000);
        expectAt("initgate_p0hit", S_VEC1, 16'h0002);
        partitionGated = 4'b0000;
        expectAt("p1init_state", S_STATE, 16'h00A6, 1);
        for (int k = 1; k <= 4; k++) expectAt("p1init_ready", S_RDY, 16'h0000, k);
        expectAt("p1init_done", S_RDY, 16'h0001, 5);
        expectAt("p1init_active", S_STATE, 16'h00AA, 5);
        step(5);
        tag[0] = 8'h15; tag[1] = 8'h16;
        expectAt("p1init_seq5", S_VEC0, 16'h0020);
        expectAt("p1init_seq6", S_VEC1, 16'h0040);

        step(3);
        check("scoreboard_drain", 16'(sbQ.size()), 16'h0000);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/cam_partitioned_dyn.md
CAM_PARTITIONED_DYN -- requirements
Module: cam_partitioned_dyn

Interface
REQ-001 Parameters SHALL be: DEPTH 64 (total entries); INDEX 6 (log2 DEPTH); WIDTH 7 (tag/data bits); NUM_WR_PORTS 4; NUM_RD_PORTS 4; NUM_PARTS 4 (power of two, at least 1); NUM_PARTS_LOG 2; RESET_VAL ZERO (ZERO or SEQ); SEQ_START 0; READ_REG 0 (0 = combinational match, 1 = registered match).
REQ-002 Ports SHALL be as follows; clock and reset come first.
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low; asserted when 0.
- writePortGated_i  input  NUM_WR_PORTS  gates write ports.
- readPortGated_i  input  NUM_RD_PORTS  gates match ports.
- partitionGated_i  input  NUM_PARTS  gates partitions.
- tag_i  input  NUM_RD_PORTS x WIDTH  search tags.
- vect_o  output  NUM_RD_PORTS x DEPTH  one-hot/multi-hot match vectors; bit i = entry i.
- addrWr_i  input  NUM_WR_PORTS x INDEX  write addresses; upper NUM_PARTS_LOG bits select the partition.
- dataWr_i  input  NUM_WR_PORTS x WIDTH  write data.
- wrEn_i  input  NUM_WR_PORTS  write enables.
- partState_o  output  NUM_PARTS x 2  per-partition state: 0 GATED, 1 INIT, 2 ACTIVE.
- ramReady_o  output  1  high when no partition is in INIT.

Function
REQ-003 Storage SHALL be DEPTH x WIDTH. It is split into NUM_PARTS partitions of PD = DEPTH/NUM_PARTS entries. Partition p holds global entries p*PD .. p*PD+PD-1. The match concatenation SHALL be generic in NUM_PARTS; nothing is hard-coded to 4.
REQ-004 Each partition SHALL run its own FSM with states GATED, INIT and ACTIVE, plus an init counter of INDEX-NUM_PARTS_LOG bits.
REQ-005 INIT SHALL write one entry per cycle, counter value i, starting at i = 0. The value written is 0 (ZERO) or SEQ_START + p*PD + i truncated to WIDTH (SEQ). After the cycle that writes entry PD-1, the FSM SHALL move to ACTIVE, or to GATED if partitionGated_i[p] is 1.
REQ-006 The following transitions SHALL apply:
- ACTIVE -> GATED when partitionGated_i[p] = 1.
- INIT -> GATED immediately when partitionGated_i[p] = 1; the counter is cleared.
- GATED -> INIT when partitionGated_i[p] = 0; INIT restarts at entry 0 and previous contents are treated as lost.
REQ-007 A write on port w SHALL commit at the rising edge only if all of these hold:
- wrEn_i[w] = 1;
- writePortGated_i[w] = 0;
- the target partition is ACTIVE in that cycle.
Otherwise the write SHALL be silently dropped. A write in the cycle a partition leaves ACTIVE is also dropped.
REQ-008 If several committing ports write the same address in one cycle, the highest-numbered port SHALL win. Different addresses SHALL all commit.
REQ-009 For each read port rp and entry e, vect_o[rp][e] SHALL be 1 iff all of these hold:
- readPortGated_i[rp] = 0;
- the partition containing e is ACTIVE;
- the stored value of e equals tag_i[rp].
REQ-010 Read/write ordering SHALL be as follows. With READ_REG = 0, vect_o is combinational and reflects contents before the same-cycle writes. With READ_REG = 1, vect_o is registered: the tag presented in cycle N gives its result in cycle N+1, evaluated on cycle-N contents and cycle-N gating.
REQ-011 ramReady_o SHALL be 0 while any partition is in INIT, and 1 otherwise.

Reset
REQ-012 When reset = 0, the following SHALL hold asynchronously:
- all FSMs go to INIT with counters at 0;
- vect_o is 0, including the READ_REG register;
- ramReady_o is 0;
- partState_o is 1 for every partition.
REQ-013 Storage SHALL have no asynchronous reset; contents are defined only by INIT. INIT SHALL begin on the first rising edge after reset deasserts.
REQ-014 If reset is asserted mid-INIT or mid-operation, all in-flight INIT progress and same-cycle writes SHALL be discarded, and INIT SHALL restart from entry 0 after release.

Verification
Common configuration for all scenarios: DEPTH 16, INDEX 4, NUM_PARTS 4, WIDTH 8, NUM_WR_PORTS 2, NUM_RD_PORTS 2, RESET_VAL SEQ, SEQ_START 0x10, READ_REG 0 unless stated.
REQ-015 Reset release, all ungated: ramReady_o = 0 for 4 cycles, then 1. Then tag_i[0] = 0x15 gives vect_o[0] = 16'h0020.
REQ-016 Write conflict: port0 and port1 both write address 9 in one cycle, with 0xAA and 0xBB respectively. Next cycle, tag 0xBB gives 16'h0200 and tag 0xAA gives 16'h0000.
REQ-017 Gating partition 2:
- set partitionGated_i = 4'b0100; tag 0x19 then gives 16'h0000;
- write address 10 with 0x55; it is dropped;
- ungate; ramReady_o = 0 for 4 cycles;
- tag 0x1A then gives 16'h0400 and tag 0x55 gives 0.
REQ-018 READ_REG = 1: tag 0x13 applied in cycle N gives vect_o[0] = 16'h0008 first in cycle N+1. If readPortGated_i[0] = 1 in cycle N, vect_o[0] = 0 in cycle N+1.
REQ-019 Reset pulse after 2 INIT cycles: outputs are 0 immediately. After release, ramReady_o stays 0 for a full 4 cycles and the SEQ values are correct.
REQ-020 Gating during INIT: partition 1 is gated in INIT cycle 2 and goes to GATED, with partState_o[1] = 0 and ramReady_o = 1 once the others finish. After ungate, partition 1 runs INIT for 4 cycles.
